// File: rtl/midi_parser_if.sv
// Byte-in / event-out bus between the UART receiver, the MIDI parser and the parameter writer.
// The master drives bytes and pops events; the slave (parser) decodes and buffers them.
interface midi_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_status;
    logic [6:0] evt_data1;
    logic [6:0] evt_data2;
    logic       overflow;
    logic       overflow_clr;

    modport master (
        output rx_valid, rx_data, evt_ready, overflow_clr,
        input  evt_valid, evt_status, evt_data1, evt_data2, overflow
    );

    modport slave (
        input  rx_valid, rx_data, evt_ready, overflow_clr,
        output evt_valid, evt_status, evt_data1, evt_data2, overflow
    );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: channel-voice messages with running status, realtime passthrough,
// SysEx skipping, and a small event FIFO with a valid/ready pop side and sticky overflow.
module midi_parser #(
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input logic          clk,
    input logic          rst,
    midi_parser_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_D1 = 2'd1;
    localparam logic [1:0] ST_WAIT_D2 = 2'd2;
    localparam logic [1:0] ST_SYSEX   = 2'd3;

    logic [1:0]  r_state, w_state_d;
    logic [7:0]  r_rs, w_rs_d;
    logic [6:0]  r_d1, w_d1_d;
    logic        w_push;
    logic [21:0] w_push_data;
    logic        w_one_byte;

    // Program change and channel pressure carry a single data byte.
    assign w_one_byte = (r_rs[7:4] == 4'hC) || (r_rs[7:4] == 4'hD);

    always_comb begin
        w_state_d   = r_state;
        w_rs_d      = r_rs;
        w_d1_d      = r_d1;
        w_push      = 1'b0;
        w_push_data = '0;
        if (bus.rx_valid) begin
            if (bus.rx_data >= 8'hF8) begin
                w_push      = 1'b1;
                w_push_data = {bus.rx_data, 7'd0, 7'd0};
            end else if (bus.rx_data[7]) begin
                if (bus.rx_data < 8'hF0) begin
                    w_rs_d    = bus.rx_data;
                    w_state_d = ST_WAIT_D1;
                end else if (bus.rx_data == 8'hF0) begin
                    w_rs_d    = '0;
                    w_state_d = ST_SYSEX;
                end else begin
                    w_rs_d    = '0;
                    w_state_d = ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_WAIT_D1: begin
                        if (w_one_byte) begin
                            w_push      = 1'b1;
                            w_push_data = {r_rs, bus.rx_data[6:0], 7'd0};
                        end else begin
                            w_d1_d    = bus.rx_data[6:0];
                            w_state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_push      = 1'b1;
                        w_push_data = {r_rs, r_d1, bus.rx_data[6:0]};
                        w_state_d   = ST_WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rs    <= '0;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_d;
            r_rs    <= w_rs_d;
            r_d1    <= w_d1_d;
        end
    end

    logic [21:0]              r_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH:0] r_wptr, r_rptr;
    logic [21:0]              r_last;
    logic                     r_overflow;
    logic                     w_empty, w_full, w_pop, w_wr, w_drop;
    logic [21:0]              w_head;

    // Extra pointer MSB distinguishes full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_ADDR_WIDTH] != r_rptr[FIFO_ADDR_WIDTH]) &&
                     (r_wptr[FIFO_ADDR_WIDTH-1:0] == r_rptr[FIFO_ADDR_WIDTH-1:0]);
    assign w_pop   = !w_empty && bus.evt_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_head  = w_empty ? r_last : r_mem[r_rptr[FIFO_ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[FIFO_ADDR_WIDTH-1:0]] <= w_push_data;
                r_wptr                             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_last <= w_head;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.evt_valid  = !w_empty;
    assign bus.evt_status = w_head[21:14];
    assign bus.evt_data1  = w_head[13:7];
    assign bus.evt_data2  = w_head[6:0];
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: stimulus pushes expected events, a negedge monitor pops
// and compares each accepted event, and unexpected events are flagged.
module tb_midi_parser;
    logic clk;
    logic rst;
    midi_parser_if bus ();

    midi_parser #(.FIFO_ADDR_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_evt(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
        exp_q.push_back({s, a, b});
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_evt_valid"}, {31'd0, bus.evt_valid}, 0);
        check({tag, "_evt_status"}, {24'd0, bus.evt_status}, 0);
        check({tag, "_evt_data1"}, {25'd0, bus.evt_data1}, 0);
        check({tag, "_evt_data2"}, {25'd0, bus.evt_data2}, 0);
        check({tag, "_overflow"}, {31'd0, bus.overflow}, 0);
    endtask

    // Monitor: every accepted event must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.evt_valid && bus.evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got %h want none",
                         {bus.evt_status, bus.evt_data1, bus.evt_data2});
            end else begin
                logic [21:0] want;
                want = exp_q.pop_front();
                if ({bus.evt_status, bus.evt_data1, bus.evt_data2} !== want) begin
                    errors++;
                    $display("FAIL event got %h want %h",
                             {bus.evt_status, bus.evt_data1, bus.evt_data2}, want);
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = '0;
        bus.evt_ready    = 1'b1;
        bus.overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Note-on, visible the cycle after the last data byte.
        expect_evt(8'h90, 7'h3C, 7'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        check("noteon_latency_valid", {31'd0, bus.evt_valid}, 1);
        settle();

        // Running status.
        expect_evt(8'h92, 7'h3C, 7'h64);
        expect_evt(8'h92, 7'h3E, 7'h00);
        send(8'h92); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00);
        settle();

        // Program change, one data byte, running status.
        expect_evt(8'hC5, 7'h07, 7'h00);
        expect_evt(8'hC5, 7'h09, 7'h00);
        send(8'hC5); send(8'h07); send(8'h09);
        settle();

        // Realtime interleaved in a note-on.
        expect_evt(8'hF8, 7'h00, 7'h00);
        expect_evt(8'hFE, 7'h00, 7'h00);
        expect_evt(8'h90, 7'h3C, 7'h64);
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        settle();

        // SysEx skipping; trailing data after F7 has no running status.
        expect_evt(8'h90, 7'h3C, 7'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
        settle();

        // System common F1-F6 discards running status.
        send(8'h90); send(8'h3C); send(8'hF3); send(8'h64); send(8'h3C); send(8'h64);
        settle();

        // Reset mid-message discards the partial message.
        send(8'h90);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        send(8'h3C); send(8'h64);
        settle();

        // Overflow: five messages into a depth-4 FIFO with the consumer stalled.
        bus.evt_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n <= 4) expect_evt(8'hB0, 7'h07, 7'(n));
            send(8'hB0); send(8'h07); send(8'(n));
        end
        @(posedge clk);
        #1;
        check("ovf_evt_valid", {31'd0, bus.evt_valid}, 1);
        check("ovf_overflow", {31'd0, bus.overflow}, 1);
        check("ovf_head", {10'd0, bus.evt_status, bus.evt_data1, bus.evt_data2},
              {10'd0, 8'hB0, 7'h07, 7'h01});
        bus.evt_ready = 1'b1;
        settle();
        check("drain_evt_valid", {31'd0, bus.evt_valid}, 0);
        check("drain_head_hold", {10'd0, bus.evt_status, bus.evt_data1, bus.evt_data2},
              {10'd0, 8'hB0, 7'h07, 7'h04});
        check("ovf_sticky", {31'd0, bus.overflow}, 1);
        bus.overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.overflow_clr = 1'b0;
        check("ovf_cleared", {31'd0, bus.overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Upstream stage of the MIDI parameter block.
- Consumes the raw MIDI byte stream from the UART receiver.
- Decodes it into complete channel-voice and realtime events, including running status and SysEx skipping.
- Buffers decoded events in a small FIFO with a valid/ready pop interface. The parameter writer drains this FIFO and updates parameter RAM.

Parameters:
- FIFO_ADDR_WIDTH, 2, log2 of event FIFO depth (depth = 2**FIFO_ADDR_WIDTH = 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  single-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received MIDI byte.
- evt_valid  output  1  FIFO non-empty; head event presented on evt_*.
- evt_ready  input  1  consumer accepts head event when evt_valid=1.
- evt_status  output  8  status byte of head event, channel in [3:0].
- evt_data1  output  7  first data byte of head event (0 if none).
- evt_data2  output  7  second data byte of head event (0 if none).
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset state: parser in IDLE, running status cleared, data latches 0, FIFO empty. Outputs: evt_valid=0, evt_status=0, evt_data1=0, evt_data2=0, overflow=0.
- Reset mid-message: a partial message is discarded and FIFO contents are lost.
- Byte acceptance: every byte with rx_valid=1 is consumed. There is no backpressure to the UART.
- Parser state machine (registered): IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Realtime bytes 0xF8-0xFF:
  - Pushed immediately as an event {byte, 0, 0} in any state.
  - State, running status and partial data are untouched.
- 0x80-0xEF (channel status):
  - Latch as running status and go to WAIT_D1.
  - Data count is 1 for 0xCn/0xDn and 2 for all others.
  - A status byte arriving in WAIT_D2 abandons the partial message.
- 0xF0: clear running status and go to SYSEX.
- 0xF7: go to IDLE with running status cleared. No event is produced.
- 0xF1-0xF6: clear running status and go to IDLE. The message is discarded.
- Data bytes 0x00-0x7F:
  - IDLE: discard.
  - SYSEX: discard and stay in SYSEX.
  - WAIT_D1, 1-byte message: push {rs, d, 0} and stay in WAIT_D1 (running status).
  - WAIT_D1, 2-byte message: latch d1 and go to WAIT_D2.
  - WAIT_D2: push {rs, d1, d} and go to WAIT_D1.
- Note-on with velocity 0 is passed unchanged. Interpreting it as note-off is the consumer's job.
- FIFO:
  - Depth 2**FIFO_ADDR_WIDTH, 22-bit entries, synchronous write.
  - Head is registered-visible: an event completed by the byte in cycle N appears on evt_* with evt_valid=1 in cycle N+1 when the FIFO was empty.
  - Pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: event dropped and overflow set to 1 next cycle. FIFO contents are unchanged.
  - Order is strictly FIFO. Pointers wrap modulo depth, and a full/empty distinction is kept via an extra pointer bit or count.
  - Only one push is possible per cycle, since one byte per cycle yields at most one event.
- overflow: set has priority over overflow_clr in the same cycle. Otherwise overflow_clr=1 clears it next cycle.
- evt_* are don't-care-stable only when evt_valid=1. When empty they hold the last head value.

Test Plan:
- Note-on: bytes 0x90,0x3C,0x64 with evt_ready=1 -> one event {0x90,0x3C,0x64}, evt_valid high the cycle after the 0x64 strobe.
- Running status: 0x92,0x3C,0x64,0x3E,0x00 -> events {0x92,0x3C,0x64} then {0x92,0x3E,0x00}.
- Program change: 0xC5,0x07,0x09 -> events {0xC5,0x07,0x00} and {0xC5,0x09,0x00}.
- Interleaved realtime: 0x90,0xF8,0x3C,0xFE,0x64 -> events in order {0xF8,0,0}, {0xFE,0,0}, {0x90,0x3C,0x64}.
- SysEx and orphan data:
  - 0x90,0x3C,0x64,0xF0,0x01,0x02,0xF7,0x3C,0x64 -> exactly one event {0x90,0x3C,0x64}.
  - Leading 0x3C with no status -> no event.
- Overflow:
  - With evt_ready=0, send five 0xB0,0x07,n messages (n=1..5) -> evt_valid=1 and overflow=1.
  - Then drain with evt_ready=1 -> data2 = 1,2,3,4, then evt_valid=0.
  - Pulse overflow_clr -> overflow=0.
  - Also: assert rst between 0x90 and 0x3C -> after release, 0x3C,0x64 produce no event.
